// File: rtl/display_fb_pkg.sv
// Shared types and constants for the display framebuffer arbiter.
package display_fb_pkg;

    localparam int FB_DW         = 32;
    localparam int DEF_FB_AW     = 16;
    localparam int DEF_BURST_LEN = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BURST    = 2'd1,
        ST_CPU_SLOT = 2'd2
    } arb_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/display_fb_arb_if.sv
// Display, CPU and SRAM bus signals of the framebuffer arbiter.
// slave = arbiter side, master = requester/memory side.
interface display_fb_arb_if
    import display_fb_pkg::*;
#(
    parameter int FB_AW = DEF_FB_AW
);
    logic             disp_req_i;
    logic [FB_AW-1:0] disp_addr_i;
    logic             disp_gnt_o;
    logic             disp_rvalid_o;
    logic [FB_DW-1:0] disp_rdata_o;

    logic             cpu_req_i;
    logic             cpu_we_i;
    logic [3:0]       cpu_be_i;
    logic [FB_AW-1:0] cpu_addr_i;
    logic [FB_DW-1:0] cpu_wdata_i;
    logic             cpu_gnt_o;
    logic             cpu_rvalid_o;
    logic [FB_DW-1:0] cpu_rdata_o;

    logic             mem_req_o;
    logic             mem_we_o;
    logic [3:0]       mem_be_o;
    logic [FB_AW-1:0] mem_addr_o;
    logic [FB_DW-1:0] mem_wdata_o;
    logic [FB_DW-1:0] mem_rdata_i;

    modport slave (
        input  disp_req_i, disp_addr_i,
        output disp_gnt_o, disp_rvalid_o, disp_rdata_o,
        input  cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
        output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output disp_req_i, disp_addr_i,
        input  disp_gnt_o, disp_rvalid_o, disp_rdata_o,
        output cpu_req_i, cpu_we_i, cpu_be_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );

endinterface

// File: rtl/display_fb_addr_gen.sv
// Burst address and beat counter: load holds start+1 (the first beat is
// issued straight from the request address), inc advances, last flags the final beat.
module display_fb_addr_gen
    import display_fb_pkg::*;
#(
    parameter int FB_AW     = DEF_FB_AW,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [FB_AW-1:0] start_i,
    output logic [FB_AW-1:0] addr_o,
    output logic             last_o
);
    localparam int            BW        = $clog2(BURST_LEN) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] ONE_BEAT  = BW'(1);
    localparam logic [FB_AW-1:0] ONE_A  = FB_AW'(1);

    logic [FB_AW-1:0] addr_q, addr_d;
    logic [BW-1:0]    beat_q, beat_d;

    // Next address/beat selection
    always_comb begin
        addr_d = addr_q;
        beat_d = beat_q;
        if (load_i) begin
            addr_d = start_i + ONE_A;
            beat_d = ONE_BEAT;
        end else if (inc_i) begin
            addr_d = addr_q + ONE_A;
            beat_d = beat_q + ONE_BEAT;
        end else begin
            addr_d = addr_q;
            beat_d = beat_q;
        end
    end

    // Address/beat registers
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            addr_q <= '0;
            beat_q <= '0;
        end else begin
            addr_q <= addr_d;
            beat_q <= beat_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (beat_q == LAST_BEAT);

endmodule

// File: rtl/display_fb_arb.sv
// Framebuffer SRAM arbiter: uninterruptible display bursts, one guaranteed CPU slot
// after each burst. Optional stall/burst counters under DISPLAY_FB_ARB_STATS_EN.
module display_fb_arb
    import display_fb_pkg::*;
#(
    parameter int FB_AW     = DEF_FB_AW,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic              clk_sys_i,
    input  logic              rst_sys_i,
    display_fb_arb_if.slave   bus,
    output logic [31:0]       stat_cpu_stall_o,
    output logic [15:0]       stat_bursts_o
);
    arb_state_e state_q, state_d;

    logic             disp_gnt_s, cpu_gnt_s, disp_issue_s;
    logic             gen_load_s, gen_inc_s, gen_last_s;
    logic [FB_AW-1:0] gen_addr_s;
    logic             mem_req_s, mem_we_s;
    logic [3:0]       mem_be_s;
    logic [FB_AW-1:0] mem_addr_s;
    logic [FB_DW-1:0] mem_wdata_s;
    logic             disp_rvalid_q, cpu_rvalid_q;

    display_fb_addr_gen #(
        .FB_AW     (FB_AW),
        .BURST_LEN (BURST_LEN)
    ) u_addr_gen (
        .clk_sys_i (clk_sys_i),
        .rst_sys_i (rst_sys_i),
        .load_i    (gen_load_s),
        .inc_i     (gen_inc_s),
        .start_i   (bus.disp_addr_i),
        .addr_o    (gen_addr_s),
        .last_o    (gen_last_s)
    );

    // Next-state, grants and SRAM mux
    always_comb begin
        state_d      = state_q;
        disp_gnt_s   = 1'b0;
        cpu_gnt_s    = 1'b0;
        disp_issue_s = 1'b0;
        gen_load_s   = 1'b0;
        gen_inc_s    = 1'b0;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        mem_be_s     = 4'h0;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.disp_req_i) begin
                    disp_gnt_s   = 1'b1;
                    disp_issue_s = 1'b1;
                    gen_load_s   = 1'b1;
                    mem_req_s    = 1'b1;
                    mem_addr_s   = bus.disp_addr_i;
                    state_d      = ST_BURST;
                end else if (bus.cpu_req_i) begin
                    cpu_gnt_s   = 1'b1;
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.cpu_we_i;
                    mem_be_s    = bus.cpu_be_i;
                    mem_addr_s  = bus.cpu_addr_i;
                    mem_wdata_s = bus.cpu_wdata_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                disp_issue_s = 1'b1;
                gen_inc_s    = 1'b1;
                mem_req_s    = 1'b1;
                mem_addr_s   = gen_addr_s;
                if (gen_last_s) begin
                    state_d = bus.cpu_req_i ? ST_CPU_SLOT : ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_CPU_SLOT: begin
                state_d = ST_IDLE;
                if (bus.cpu_req_i) begin
                    cpu_gnt_s   = 1'b1;
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.cpu_we_i;
                    mem_be_s    = bus.cpu_be_i;
                    mem_addr_s  = bus.cpu_addr_i;
                    mem_wdata_s = bus.cpu_wdata_i;
                end else begin
                    mem_req_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and read-valid pipeline registers
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q       <= ST_IDLE;
            disp_rvalid_q <= 1'b0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            disp_rvalid_q <= disp_issue_s;
            cpu_rvalid_q  <= cpu_gnt_s;
        end
    end

    assign bus.disp_gnt_o    = disp_gnt_s;
    assign bus.cpu_gnt_o     = cpu_gnt_s;
    assign bus.disp_rvalid_o = disp_rvalid_q;
    assign bus.cpu_rvalid_o  = cpu_rvalid_q;
    assign bus.disp_rdata_o  = bus.mem_rdata_i;
    assign bus.cpu_rdata_o   = bus.mem_rdata_i;
    assign bus.mem_req_o     = mem_req_s;
    assign bus.mem_we_o      = mem_we_s;
    assign bus.mem_be_o      = mem_be_s;
    assign bus.mem_addr_o    = mem_addr_s;
    assign bus.mem_wdata_o   = mem_wdata_s;

`ifdef DISPLAY_FB_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] bursts_q, bursts_d;

    // Saturating stall and burst counters
    always_comb begin
        stall_d  = stall_q;
        bursts_d = bursts_q;
        if (bus.cpu_req_i && !cpu_gnt_s) begin
            stall_d = sat_inc32(stall_q);
        end else begin
            stall_d = stall_q;
        end
        if (disp_gnt_s) begin
            bursts_d = sat_inc16(bursts_q);
        end else begin
            bursts_d = bursts_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            stall_q  <= 32'd0;
            bursts_q <= 16'd0;
        end else begin
            stall_q  <= stall_d;
            bursts_q <= bursts_d;
        end
    end

    assign stat_cpu_stall_o = stall_q;
    assign stat_bursts_o    = bursts_q;
`else
    assign stat_cpu_stall_o = 32'd0;
    assign stat_bursts_o    = 16'd0;
`endif

endmodule

// File: tb/tb_display_fb_arb.sv
// Directed bench for display_fb_arb with an SRAM model and queue scoreboards.
module tb_display_fb_arb;
    import display_fb_pkg::*;

    localparam int AW = 16;
    localparam int BL = 8;
`ifdef DISPLAY_FB_ARB_STATS_EN
    localparam logic [31:0] EXP_STALL  = 32'd8;
    localparam logic [31:0] EXP_BURSTS = 32'd1;
`else
    localparam logic [31:0] EXP_STALL  = 32'd0;
    localparam logic [31:0] EXP_BURSTS = 32'd0;
`endif

    typedef struct packed { logic we; logic [15:0] addr; } mem_exp_t;
    typedef struct packed { logic rd; logic [31:0] data; } cpu_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stat_stall;
    logic [15:0] stat_bursts;
    int          checks = 0;
    int          passed = 0;

    mem_exp_t    mem_q[$];
    logic [31:0] disp_q[$];
    cpu_exp_t    cpu_q[$];
    logic [31:0] mem [logic [15:0]];

    mem_exp_t    mon_m;
    logic [31:0] mon_d;
    cpu_exp_t    mon_c;

    display_fb_arb_if #(.FB_AW(AW)) bus();

    display_fb_arb #(.FB_AW(AW), .BURST_LEN(BL)) dut (
        .clk_sys_i        (clk),
        .rst_sys_i        (rst),
        .bus              (bus),
        .stat_cpu_stall_o (stat_stall),
        .stat_bursts_o    (stat_bursts)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input logic [15:0] start);
        for (int i = 0; i < BL; i++) begin
            logic [15:0] a;
            a = start + 16'(i);
            mem_q.push_back({1'b0, a});
            disp_q.push_back(pat(a));
        end
    endtask

    // SRAM model: data returned one cycle after the request
    always @(posedge clk) begin
        if (bus.mem_req_o === 1'b1) begin
            logic [31:0] cur;
            cur = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o] : pat(bus.mem_addr_o);
            bus.mem_rdata_i <= cur;
            if (bus.mem_we_o === 1'b1) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be_o[b]) cur[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
                end
                mem[bus.mem_addr_o] = cur;
            end
        end
    end

    // Scoreboard monitors
    always @(negedge clk) begin
        if (bus.mem_req_o === 1'b1) begin
            chk1("mem_issue_expected", mem_q.size() != 0, 1'b1);
            if (mem_q.size() != 0) begin
                mon_m = mem_q.pop_front();
                chk32("mem_addr", 32'(bus.mem_addr_o), 32'(mon_m.addr));
                chk1("mem_we", bus.mem_we_o, mon_m.we);
            end
        end
        if (bus.disp_rvalid_o === 1'b1) begin
            chk1("disp_rvalid_expected", disp_q.size() != 0, 1'b1);
            if (disp_q.size() != 0) begin
                mon_d = disp_q.pop_front();
                chk32("disp_rdata", bus.disp_rdata_o, mon_d);
            end
        end
        if (bus.cpu_rvalid_o === 1'b1) begin
            chk1("cpu_rvalid_expected", cpu_q.size() != 0, 1'b1);
            if (cpu_q.size() != 0) begin
                mon_c = cpu_q.pop_front();
                if (mon_c.rd) chk32("cpu_rdata", bus.cpu_rdata_o, mon_c.data);
            end
        end
    end

    initial begin
        int cpu_gnts;
        int disp_gnts;
        bus.disp_req_i  = 1'b0;
        bus.disp_addr_i = 16'h0000;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_be_i    = 4'h0;
        bus.cpu_addr_i  = 16'h0000;
        bus.cpu_wdata_i = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_disp_gnt", bus.disp_gnt_o, 1'b0);
        chk1("rst_cpu_gnt", bus.cpu_gnt_o, 1'b0);
        chk1("rst_mem_req", bus.mem_req_o, 1'b0);
        chk1("rst_disp_rvalid", bus.disp_rvalid_o, 1'b0);
        chk1("rst_cpu_rvalid", bus.cpu_rvalid_o, 1'b0);
        chk32("rst_stat_stall", stat_stall, 32'd0);
        chk32("rst_stat_bursts", 32'(stat_bursts), 32'd0);

        // CPU write, read back, partial-byte write and read back
        next();
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_be_i = 4'hF;
        bus.cpu_addr_i = 16'h0010; bus.cpu_wdata_i = 32'hDEAD_BEEF;
        mem_q.push_back({1'b1, 16'h0010}); cpu_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        chk1("cpu_wr_gnt", bus.cpu_gnt_o, 1'b1);
        chk1("cpu_wr_mem_we", bus.mem_we_o, 1'b1);
        chk32("cpu_wr_mem_be", 32'(bus.mem_be_o), 32'hF);
        chk32("cpu_wr_mem_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        next();
        bus.cpu_we_i = 1'b0;
        mem_q.push_back({1'b0, 16'h0010}); cpu_q.push_back({1'b1, 32'hDEAD_BEEF});
        @(negedge clk);
        chk1("cpu_wr_rvalid", bus.cpu_rvalid_o, 1'b1);
        chk1("cpu_rd_gnt", bus.cpu_gnt_o, 1'b1);
        next();
        bus.cpu_we_i = 1'b1; bus.cpu_be_i = 4'b0101;
        bus.cpu_addr_i = 16'h0020; bus.cpu_wdata_i = 32'h1122_3344;
        mem_q.push_back({1'b1, 16'h0020}); cpu_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        chk1("cpu_rd_rvalid", bus.cpu_rvalid_o, 1'b1);
        chk32("cpu_part_mem_be", 32'(bus.mem_be_o), 32'h5);
        next();
        bus.cpu_we_i = 1'b0;
        mem_q.push_back({1'b0, 16'h0020});
        cpu_q.push_back({1'b1, (pat(16'h0020) & 32'hFF00_FF00) | 32'h0022_0044});
        @(negedge clk);
        next();
        bus.cpu_req_i = 1'b0;
        @(negedge clk);
        chk1("cpu_last_rvalid", bus.cpu_rvalid_o, 1'b1);
        chk1("cpu_idle_no_gnt", bus.cpu_gnt_o, 1'b0);
        chk1("cpu_idle_no_mem", bus.mem_req_o, 1'b0);
        next();
        @(negedge clk);
        chk1("cpu_rvalid_drop", bus.cpu_rvalid_o, 1'b0);

        // Plain burst at 0x0100, request dropped after the grant
        next();
        bus.disp_req_i = 1'b1; bus.disp_addr_i = 16'h0100;
        push_burst(16'h0100);
        @(negedge clk);
        chk1("burst_gnt", bus.disp_gnt_o, 1'b1);
        chk1("burst_gnt_rvalid", bus.disp_rvalid_o, 1'b0);
        chk32("burst_mem_be", 32'(bus.mem_be_o), 32'h0);
        next();
        bus.disp_req_i = 1'b0;
        for (int i = 1; i < BL; i++) begin
            @(negedge clk);
            chk1("burst_beat_rvalid", bus.disp_rvalid_o, 1'b1);
            chk1("burst_beat_no_gnt", bus.disp_gnt_o, 1'b0);
            chk1("burst_beat_mem_req", bus.mem_req_o, 1'b1);
            next();
        end
        @(negedge clk);
        chk1("burst_last_rvalid", bus.disp_rvalid_o, 1'b1);
        chk1("burst_end_mem_req", bus.mem_req_o, 1'b0);
        next();
        @(negedge clk);
        chk1("burst_rvalid_drop", bus.disp_rvalid_o, 1'b0);

        // Display and CPU together, display held: burst, one CPU slot, burst
        next();
        bus.disp_req_i = 1'b1; bus.disp_addr_i = 16'h0200;
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 16'h0030;
        push_burst(16'h0200);
        mem_q.push_back({1'b0, 16'h0030}); cpu_q.push_back({1'b1, pat(16'h0030)});
        push_burst(16'h0300);
        cpu_gnts = 0;
        disp_gnts = 0;
        for (int c = 0; c < 17; c++) begin
            @(negedge clk);
            cpu_gnts += 32'(bus.cpu_gnt_o);
            disp_gnts += 32'(bus.disp_gnt_o);
            if (c == 0) begin
                chk1("both_disp_wins", bus.disp_gnt_o, 1'b1);
                chk1("both_cpu_waits", bus.cpu_gnt_o, 1'b0);
            end
            if (c == 8) begin
                chk1("slot_cpu_gnt", bus.cpu_gnt_o, 1'b1);
                chk1("slot_no_disp_gnt", bus.disp_gnt_o, 1'b0);
            end
            if (c == 9) chk1("second_burst_gnt", bus.disp_gnt_o, 1'b1);
            next();
            if (c == 0) bus.disp_addr_i = 16'h0300;
            if (c == 8) bus.cpu_req_i = 1'b0;
            if (c == 9) bus.disp_req_i = 1'b0;
        end
        chk32("fair_cpu_gnt_count", 32'(cpu_gnts), 32'd1);
        chk32("fair_disp_gnt_count", 32'(disp_gnts), 32'd2);
        repeat (3) next();

        // Burst wrapping the top of the address space
        bus.disp_req_i = 1'b1; bus.disp_addr_i = 16'hFFFC;
        push_burst(16'hFFFC);
        @(negedge clk);
        chk1("wrap_gnt", bus.disp_gnt_o, 1'b1);
        next();
        bus.disp_req_i = 1'b0;
        repeat (3) next();
        @(negedge clk);
        chk32("wrap_addr_zero", 32'(bus.mem_addr_o), 32'h0000);
        repeat (6) next();

        // Reset on the 4th beat abandons the rest of the burst
        bus.disp_req_i = 1'b1; bus.disp_addr_i = 16'h0400;
        for (int i = 0; i < 4; i++) mem_q.push_back({1'b0, 16'h0400 + 16'(i)});
        for (int i = 0; i < 3; i++) disp_q.push_back(pat(16'h0400 + 16'(i)));
        @(negedge clk);
        next();
        bus.disp_req_i = 1'b0;
        next();
        next();
        rst = 1'b1;
        @(negedge clk);
        chk32("rst_beat4_addr", 32'(bus.mem_addr_o), 32'h0403);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_disp_rvalid", bus.disp_rvalid_o, 1'b0);
        chk1("post_rst_mem_req", bus.mem_req_o, 1'b0);
        chk1("post_rst_disp_gnt", bus.disp_gnt_o, 1'b0);
        chk32("post_rst_stat_stall", stat_stall, 32'd0);

        // Fresh burst after reset with a CPU request blocked behind it
        next();
        bus.disp_req_i = 1'b1; bus.disp_addr_i = 16'h0500;
        bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 16'h0040;
        push_burst(16'h0500);
        mem_q.push_back({1'b0, 16'h0040}); cpu_q.push_back({1'b1, pat(16'h0040)});
        @(negedge clk);
        chk1("clean_burst_gnt", bus.disp_gnt_o, 1'b1);
        next();
        bus.disp_req_i = 1'b0;
        repeat (7) next();
        @(negedge clk);
        chk1("clean_slot_cpu_gnt", bus.cpu_gnt_o, 1'b1);
        next();
        bus.cpu_req_i = 1'b0;
        @(negedge clk);
        chk32("stat_cpu_stall", stat_stall, EXP_STALL);
        chk32("stat_bursts", 32'(stat_bursts), EXP_BURSTS);

        repeat (3) next();
        chk32("mem_q_drained", 32'(mem_q.size()), 32'd0);
        chk32("disp_q_drained", 32'(disp_q.size()), 32'd0);
        chk32("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
